// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor with on-the-fly inverse key schedule; `KEY_CACHE_EN adds an rk10 cache for repeated keys.
// Latency 21 clocks from accept to out_valid (11 on a cache hit); result held in DONE until out_ready, in_ready only in IDLE.
module aes_inv_cipher_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] C,
  input  logic [127:0] K,
  output logic [127:0] P,
  output logic         out_valid,
  input  logic         out_ready
);
  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_ADD0, S_ROUND, S_LAST, S_DONE} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{~a, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ISBOX[{~a, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a     = c[31-8*i -: 8];
      x2    = xt(a);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_t       r_state, w_state_nxt;
  logic [127:0] r_s, r_k, r_p;
  logic [3:0]   r_rnd;
  logic         r_out_vld;
  logic [7:0]   w_rcon;
  logic [31:0]  w_sw, w_f0, w_f1, w_f2, w_f3, w_b0, w_b1, w_b2, w_b3;
  logic [127:0] w_k_next, w_k_prev, w_isb, w_rnd_in, w_imc, w_hit_rk;
  logic         w_hit;

  always_comb begin
    case (r_rnd)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // One SubWord serves both directions: forward reads w3, inverse reads the recovered w3'.
  assign w_b3 = r_k[31:0] ^ r_k[63:32];
  assign w_b2 = r_k[63:32] ^ r_k[95:64];
  assign w_b1 = r_k[95:64] ^ r_k[127:96];
  assign w_sw = sub_rot((r_state == S_KEXP) ? r_k[31:0] : w_b3) ^ {w_rcon, 24'h0};
  assign w_b0 = r_k[127:96] ^ w_sw;
  assign w_f0 = r_k[127:96] ^ w_sw;
  assign w_f1 = r_k[95:64] ^ w_f0;
  assign w_f2 = r_k[63:32] ^ w_f1;
  assign w_f3 = r_k[31:0] ^ w_f2;
  assign w_k_next = {w_f0, w_f1, w_f2, w_f3};
  assign w_k_prev = {w_b0, w_b1, w_b2, w_b3};

  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int ROW = i % 4;
    localparam int SRC = ROW + 4 * (((i / 4) - ROW + 4) % 4);
    assign w_isb[127-8*i -: 8] = inv_sbox(r_s[127-8*SRC -: 8]);
  end
  assign w_rnd_in = w_isb ^ w_k_prev;
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign w_imc[127-32*c -: 32] = inv_mix_col(w_rnd_in[127-32*c -: 32]);
  end

`ifdef KEY_CACHE_EN
  logic [127:0] r_ck, r_crk;
  logic         r_cvld;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ck   <= '0;
      r_crk  <= '0;
      r_cvld <= 1'b0;
    end else begin
      if (r_state == S_IDLE && in_valid && !w_hit) begin
        r_ck   <= K;
        r_cvld <= 1'b0;
      end
      if (r_state == S_KEXP && r_rnd == 4'd10) begin
        r_crk  <= w_k_next;
        r_cvld <= 1'b1;
      end
    end
  end
  assign w_hit    = r_cvld && (K == r_ck);
  assign w_hit_rk = r_crk;
`else
  assign w_hit    = 1'b0;
  assign w_hit_rk = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = w_hit ? S_ADD0 : S_KEXP;
      S_KEXP:  if (r_rnd == 4'd10) w_state_nxt = S_ADD0;
      S_ADD0:  w_state_nxt = S_ROUND;
      S_ROUND: if (r_rnd == 4'd2) w_state_nxt = S_LAST;
      S_LAST:  w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s       <= '0;
      r_k       <= '0;
      r_p       <= '0;
      r_rnd     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_s   <= C;
          r_k   <= w_hit ? w_hit_rk : K;
          r_rnd <= 4'd1;
        end
        S_KEXP: begin
          r_k   <= w_k_next;
          r_rnd <= r_rnd + 4'd1;
        end
        S_ADD0: begin
          r_s   <= r_s ^ r_k;
          r_rnd <= 4'd10;
        end
        S_ROUND: begin
          r_s   <= w_imc;
          r_k   <= w_k_prev;
          r_rnd <= r_rnd - 4'd1;
        end
        S_LAST: begin
          r_p       <= w_rnd_in;
          r_out_vld <= 1'b1;
        end
        S_DONE: if (out_ready) r_out_vld <= 1'b0;
        default: ;
      endcase
    end
  end

  assign P         = r_p;
  assign out_valid = r_out_vld;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter: known-answer vectors, back-pressure, mid-run reset, key-cache latency.
module tb_aes_inv_cipher_iter;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] C, K, P;

  localparam logic [127:0] V1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V2K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2C = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2P = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ZC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
`ifdef KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif

  typedef struct {
    logic [127:0] p;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   rise_cyc = 0;
  logic prev_vld = 1'b0;

  aes_inv_cipher_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .C(C), .K(K), .P(P), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (out_valid && !prev_vld) rise_cyc = cyc;
    prev_vld = out_valid;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got P=%h, expected no output", P);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("plaintext", P, e.p);
        chk_int("latency_cycle", rise_cyc, e.due);
      end
    end
  end

  task automatic send(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p, input int lat);
    int w;
    w = 0;
    C = c;
    K = k;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", w);
    end else begin
      sb_q.push_back('{p, cyc + 1 + lat});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int w;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    C = '0;
    K = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_P", P, 128'd0);
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    send(V1C, V1K, V1P, 21);
    drain();

    // Back-pressure: hold out_ready low and offer a competing block.
    out_ready = 1'b0;
    send(V2C, V2K, V2P, 21);
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp_out_valid_rise", {127'd0, out_valid}, 128'd1);
    C = V1C;
    K = V1K;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid_held", {127'd0, out_valid}, 128'd1);
      chk("bp_P_held", P, V2P);
      chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", {127'd0, in_ready}, 128'd1);
    chk("bp_out_valid_after", {127'd0, out_valid}, 128'd0);
    chk("P_retained", P, V2P);
    drain();

    send(V2C, V2K, V2P, HIT_LAT);
    drain();
    send(ZC, 128'd0, 128'd0, 21);
    drain();
    send(V1C, V1K, V1P, 21);
    send(V1C, V1K, V1P, HIT_LAT);
    drain();

    // Abort mid-ROUND, then confirm a clean restart.
    send(V1C, V1K, V1P, 21);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_P", P, 128'd0);
    chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(V1C, V1K, V1P, 21);
    drain();

    repeat (30) @(posedge clk);
    #1;
    chk_int("no_stray_output", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
